// File: rtl/addsub_bist_ctrl_pkg.sv
// addsub_pkg: shared types and helpers for the adder/subtracter BIST slice.
//
// Contents:
//   state_t          controller states IDLE / RUN / DONE
//   MAX_WIDTH        widest operand the golden function supports (8)
//   DEFAULT_*        vector-space sizes for the default 4-bit adder
//   vec_bits()       counter width {m, a, b} for a given operand width
//   err_bits()       error-counter width, large enough to hold N
//   addsub_expected  golden {c, s} for one vector, returned right-aligned
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 8;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_CNT_BITS = 2 * DEFAULT_WIDTH + 1;
  localparam int DEFAULT_N        = 1 << DEFAULT_CNT_BITS;

  function automatic int vec_bits(input int width);
    return 2 * width + 1;
  endfunction

  // One extra bit over the counter so the full count N still fits.
  function automatic int err_bits(input int width);
    return 2 * width + 2;
  endfunction

  // Operands are zero-extended to MAX_WIDTH; only the low 'width' bits matter.
  // Subtract is a + ~b + 1, so the carry lands on bit 'width' exactly when
  // a >= b, and every bit above it is zero.
  function automatic logic [MAX_WIDTH:0] addsub_expected(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 m,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] b_eff;
    logic [MAX_WIDTH:0]   sum;
    mask  = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    b_eff = (m ? ~b : b) & mask;
    sum   = {1'b0, a & mask} + {1'b0, b_eff} + {{MAX_WIDTH{1'b0}}, m};
    return sum;
  endfunction

endpackage

// File: rtl/addsub_ref_model.sv
// addsub_ref_model: purely combinational golden adder/subtracter.
//
// Ports:
//   a, b  WIDTH-bit operands
//   m     0 = add, 1 = subtract
//   s     WIDTH-bit result
//   c     carry-out (for subtract: 1 when a >= b unsigned)
module addsub_ref_model
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  assign {c, s} = (WIDTH + 1)'(addsub_expected(MAX_WIDTH'(a), MAX_WIDTH'(b), m, WIDTH));

endmodule

// File: rtl/addsub_bist_ctrl.sv
// addsub_bist_ctrl: BIST initiator/checker for an external WIDTH-bit
// ripple-carry adder/subtracter. Sweeps every {m, a, b} combination,
// compares the adder response against a golden model and reports a result.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse that begins a sweep (ignored while busy)
//   a_out      operand X to the adder
//   b_out      operand Y to the adder
//   m_out      adder mode, 0 = add, 1 = subtract
//   s_in       adder sum (combinational response to a_out/b_out/m_out)
//   c_in       adder carry-out
//   busy       high while vectors are being applied
//   done       high from sweep completion until the next start or reset
//   pass       valid with done; 1 when no vector mismatched
//   err_count  number of mismatching vectors in the last sweep
//
// Optional build macro ADDSUB_BIST_STOP_ON_FAIL_EN: the first mismatch ends
// the sweep and leaves the failing vector on a_out/b_out/m_out.
module addsub_bist_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 m_out,
  input  logic [WIDTH-1:0]     s_in,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count
);

  localparam int CNT_BITS = vec_bits(WIDTH);
  localparam int ERR_BITS = err_bits(WIDTH);

  state_t              state;
  state_t              state_next;
  logic [CNT_BITS-1:0] vec;
  logic [CNT_BITS-1:0] vec_next;
  logic                busy_next;
  logic                done_next;
  logic                pass_next;
  logic [ERR_BITS-1:0] err_next;

  logic [WIDTH-1:0]    exp_s;
  logic                exp_c;
  logic                mismatch;
  logic                last_vec;
  logic [ERR_BITS-1:0] err_inc;

  // The vector register is the operand outputs, so they stay registered.
  assign m_out = vec[2*WIDTH];
  assign a_out = vec[2*WIDTH-1:WIDTH];
  assign b_out = vec[WIDTH-1:0];

  addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a(a_out),
    .b(b_out),
    .m(m_out),
    .s(exp_s),
    .c(exp_c)
  );

  assign mismatch = ({c_in, s_in} != {exp_c, exp_s});
  assign last_vec = &vec;
  assign err_inc  = err_count + ERR_BITS'(mismatch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      vec       <= vec_next;
      busy      <= busy_next;
      done      <= done_next;
      pass      <= pass_next;
      err_count <= err_next;
    end
  end

  // The response checked at each RUN edge belongs to the vector currently
  // driven, so the final edge both checks vector N-1 and closes the sweep;
  // the pass decision therefore uses the count including that last check.
  always_comb begin
    state_next = state;
    vec_next   = vec;
    busy_next  = busy;
    done_next  = done;
    pass_next  = pass;
    err_next   = err_count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          vec_next   = '0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          pass_next  = 1'b0;
          err_next   = '0;
        end
      end
      RUN: begin
        err_next = err_inc;
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = 1'b0;
        end else if (last_vec) begin
          state_next = DONE;
          vec_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (err_inc == '0);
        end else begin
          vec_next = vec + CNT_BITS'(1);
        end
`else
        if (last_vec) begin
          state_next = DONE;
          vec_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (err_inc == '0);
        end else begin
          vec_next = vec + CNT_BITS'(1);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_addsub_bist_ctrl.sv
// tb_addsub_bist_ctrl: self-checking bench for addsub_bist_ctrl (WIDTH=4).
// A bench-side adder with selectable faults answers the controller; a
// transaction-level model predicts every registered output each cycle.
module tb_addsub_bist_ctrl;

  localparam int W = 4;
  localparam int N = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       m_out;
  logic [3:0] s_in;
  logic       c_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_count;

  logic [3:0] tb_ra = 4'd0;
  logic [3:0] tb_rb = 4'd0;
  logic       tb_rm = 1'b0;
  logic [3:0] ref_s;
  logic       ref_c;

  int fault_mode = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Adder answer from plain integer arithmetic: subtract is a + 16 - b,
  // whose bit 4 is set exactly when a >= b.
  function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b, input logic m);
    int r;
    if (m) r = int'(a) + 16 - int'(b);
    else   r = int'(a) + int'(b);
    return r[4:0];
  endfunction

  // Fault 1: sum bit 0 stuck at 0. Fault 2: carry forced to 0 in subtract.
  function automatic logic [4:0] bench_adder(input logic [3:0] a, input logic [3:0] b,
                                             input logic m, input int f);
    logic [4:0] r;
    r = golden(a, b, m);
    if (f == 1) r[0] = 1'b0;
    if (f == 2 && m) r[4] = 1'b0;
    return r;
  endfunction

  assign {c_in, s_in} = bench_adder(a_out, b_out, m_out, fault_mode);

  addsub_bist_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a_out(a_out),
    .b_out(b_out),
    .m_out(m_out),
    .s_in(s_in),
    .c_in(c_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count)
  );

  addsub_ref_model #(.WIDTH(W)) u_ref (
    .a(tb_ra),
    .b(tb_rb),
    .m(tb_rm),
    .s(ref_s),
    .c(ref_c)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Model state: 0 idle, 1 sweeping, 2 finished. idx is the {m,a,b} index.
  int mdl_state = 0;
  int mdl_idx = 0;
  int mdl_errs = 0;
  bit mdl_pass = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [3:0] va;
    logic [3:0] vb;
    logic       vm;
    bit         bad_vec;
    if (reset) begin
      mdl_state = 0;
      mdl_idx   = 0;
      mdl_errs  = 0;
      mdl_pass  = 1'b0;
    end else if (mdl_state == 1) begin
      va = 4'((mdl_idx / 16) % 16);
      vb = 4'(mdl_idx % 16);
      vm = (mdl_idx >= 256);
      bad_vec = (bench_adder(va, vb, vm, fault_mode) != golden(va, vb, vm));
      if (bad_vec) mdl_errs++;
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
      if (bad_vec) begin
        mdl_state = 2;
        mdl_pass  = 1'b0;
      end else if (mdl_idx == N - 1) begin
        mdl_state = 2;
        mdl_pass  = (mdl_errs == 0);
        mdl_idx   = 0;
      end else begin
        mdl_idx++;
      end
`else
      if (mdl_idx == N - 1) begin
        mdl_state = 2;
        mdl_pass  = (mdl_errs == 0);
        mdl_idx   = 0;
      end else begin
        mdl_idx++;
      end
`endif
    end else if (start) begin
      mdl_state = 1;
      mdl_idx   = 0;
      mdl_errs  = 0;
      mdl_pass  = 1'b0;
    end
  end

  // Every cycle, all outputs packed as {busy,done,pass,err,a,b,m}.
  always @(posedge clk) begin
    logic [21:0] exp_v;
    #2;
    exp_v = {(mdl_state == 1), (mdl_state == 2), mdl_pass, 10'(mdl_errs),
             4'((mdl_idx / 16) % 16), 4'(mdl_idx % 16), (mdl_idx >= 256)};
    checkOutput("cycle_outputs", 32'({busy, done, pass, err_count, a_out, b_out, m_out}), 32'(exp_v));
  end

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'({busy, done, pass, err_count, a_out, b_out, m_out}), 32'd0);
    reset = 1'b0;

    tb_ra = 4'b1100; tb_rb = 4'b0011; tb_rm = 1'b1;
    #1;
    checkOutput("ref_spot1", 32'({ref_c, ref_s}), 32'h19);
    checkOutput("golden_spot1", 32'(golden(4'b1100, 4'b0011, 1'b1)), 32'h19);
    tb_ra = 4'b0100; tb_rb = 4'b1100; tb_rm = 1'b1;
    #1;
    checkOutput("ref_spot2", 32'({ref_c, ref_s}), 32'h08);
    checkOutput("golden_spot2", 32'(golden(4'b0100, 4'b1100, 1'b1)), 32'h08);

    // Clean sweep with a correct adder.
    fault_mode = 0;
    applyStimulus();
    checkOutput("vector0", 32'({busy, a_out, b_out, m_out}), 32'({1'b1, 4'd0, 4'd0, 1'b0}));
    repeat (5) @(negedge clk);
    checkOutput("vector5", 32'({a_out, b_out, m_out}), 32'({4'd0, 4'd5, 1'b0}));
    waitDone(n);
    checkOutput("busy_cycles", 32'(5 + n), 32'd512);
    checkOutput("clean_result", 32'({busy, done, pass, err_count}), 32'({1'b0, 1'b1, 1'b1, 10'd0}));

    // Sum bit 0 stuck at 0, then restart from DONE with a good adder.
    fault_mode = 1;
    applyStimulus();
    waitDone(n);
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
    checkOutput("stuck_cycles", 32'(n), 32'd2);
    checkOutput("stuck_result", 32'({pass, err_count, a_out, b_out, m_out}),
                32'({1'b0, 10'd1, 4'd0, 4'd1, 1'b0}));
`else
    checkOutput("stuck_result", 32'({pass, err_count, a_out, b_out, m_out}),
                32'({1'b0, 10'd256, 4'd0, 4'd0, 1'b0}));
`endif
    fault_mode = 0;
    applyStimulus();
    checkOutput("restart_clear", 32'({busy, done, err_count}), 32'({1'b1, 1'b0, 10'd0}));
    waitDone(n);
    checkOutput("restart_cycles", 32'(n), 32'd512);
    checkOutput("restart_pass", 32'(pass), 32'd1);

    // Carry forced low during subtract.
    fault_mode = 2;
    applyStimulus();
    waitDone(n);
`ifdef ADDSUB_BIST_STOP_ON_FAIL_EN
    checkOutput("carry_result", 32'({pass, err_count, a_out, b_out, m_out}),
                32'({1'b0, 10'd1, 4'd0, 4'd0, 1'b1}));
`else
    checkOutput("carry_result", 32'({pass, err_count}), 32'({1'b0, 10'd136}));
`endif
    fault_mode = 0;

    // Reset 200 cycles into a sweep, then a full clean sweep.
    applyStimulus();
    repeat (199) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset", 32'({busy, done, pass, err_count, a_out, b_out, m_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus();
    waitDone(n);
    checkOutput("post_reset_cycles", 32'(n), 32'd512);
    checkOutput("post_reset_pass", 32'({pass, err_count}), 32'({1'b1, 10'd0}));

    // A start pulse at cycle 100 of the sweep must not disturb it.
    applyStimulus();
    repeat (99) @(negedge clk);
    applyStimulus();
    waitDone(n);
    checkOutput("ignored_start_cycles", 32'(101 + n), 32'd512);
    checkOutput("ignored_start_pass", 32'(pass), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
